// File: rtl/apb3_requester_traffic_gen_if.sv
// APB3 request/completion bundle between the traffic generator and a completer.
// Latency: none, wires only.
// Backpressure: the completer stalls the requester by holding pready low.
interface apb3_requester_traffic_gen_if #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
);
    logic [AddressWidth-1:0] paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DataWidth-1:0]    pwdata;
    logic [DataWidth-1:0]    prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb3_requester_traffic_gen.sv
// APB3 requester: writes a seeded pattern to TransferCount words, reads them back and counts errors.
// Latency: psel rises the cycle after start is seen; each transfer is SETUP + >=1 ACCESS (+1 GAP if spaced).
// Backpressure: pready low stretches ACCESS; TimeoutCycles low cycles abort the transfer and count a timeout.
module apb3_requester_traffic_gen #(
    parameter int                    AddressWidth  = 32,
    parameter int                    DataWidth     = 32,
    parameter int                    TransferCount = 8,
    parameter logic [AddressWidth-1:0] BaseAddress = '0,
    parameter logic [31:0]           Seed          = 32'hA5A5_0000,
    parameter int unsigned           Stride        = 1,
    parameter int unsigned           TimeoutCycles = 16
) (
    input  logic                         pclk,
    input  logic                         presetn,
    input  logic                         start,
    input  logic                         back2back,
    apb3_requester_traffic_gen_if.master apb,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   err_count,
    output logic [7:0]                   mismatch_count,
    output logic [7:0]                   timeout_count
);

    localparam int IdxW         = (TransferCount > 1) ? $clog2(TransferCount) : 1;
    localparam int ToW          = $clog2(TimeoutCycles + 1);
    localparam int BytesPerWord = DataWidth / 8;

    localparam logic [IdxW-1:0] LastIdx  = IdxW'(TransferCount - 1);
    localparam logic [ToW-1:0]  LastWait = ToW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [IdxW-1:0]  idx, idx_nxt;
    logic             phase_rd, phase_rd_nxt;   // 0 = write phase, 1 = read-back phase
    logic             b2b, b2b_nxt;             // back2back captured at start
    logic [ToW-1:0]   wait_cnt, wait_cnt_nxt;   // consecutive pready-low ACCESS cycles
    logic             cnt_clr;
    logic             err_inc, mis_inc, to_inc;

    logic [DataWidth-1:0]    pattern;
    logic [AddressWidth-1:0] word_addr;
    logic                    in_xfer;

    // Saturating +1 used by all three event counters.
    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
        return (en && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

    // Word address and expected pattern for the current index; both wrap naturally at their width.
    always_comb begin
        pattern   = DataWidth'(Seed) + DataWidth'(idx) * DataWidth'(Stride);
        word_addr = BaseAddress + AddressWidth'(idx) * AddressWidth'(BytesPerWord);
    end

    // Bus and status outputs decode straight from state so reset clears them without waiting for a clock.
    always_comb begin
        in_xfer     = (state == ST_SETUP) || (state == ST_ACCESS);
        apb.psel    = in_xfer;
        apb.penable = (state == ST_ACCESS);
        apb.pwrite  = in_xfer && !phase_rd;
        apb.paddr   = in_xfer ? word_addr : '0;
        apb.pwdata  = (in_xfer && !phase_rd) ? pattern : '0;
        busy        = in_xfer || (state == ST_GAP);
        done        = (state == ST_DONE);
    end

    // Next state, word/phase sequencing, timeout tracking and completion checks.
    always_comb begin
        logic xfer_end;
        state_nxt    = state;
        idx_nxt      = idx;
        phase_rd_nxt = phase_rd;
        b2b_nxt      = b2b;
        wait_cnt_nxt = wait_cnt;
        cnt_clr      = 1'b0;
        err_inc      = 1'b0;
        mis_inc      = 1'b0;
        to_inc       = 1'b0;
        xfer_end     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt    = ST_SETUP;
                    idx_nxt      = '0;
                    phase_rd_nxt = 1'b0;
                    b2b_nxt      = back2back;
                    cnt_clr      = 1'b1;
                end
            end

            ST_SETUP: begin
                state_nxt    = ST_ACCESS;
                wait_cnt_nxt = '0;
            end

            ST_ACCESS: begin
                if (apb.pready) begin
                    xfer_end = 1'b1;
                    if (apb.pslverr) begin
                        err_inc = 1'b1;
                    end else if (phase_rd && (apb.prdata != pattern)) begin
                        mis_inc = 1'b1;
                    end
                end else if (wait_cnt == LastWait) begin
                    // Abandon the stuck transfer; nothing was returned, so nothing is compared.
                    xfer_end = 1'b1;
                    to_inc   = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end

                if (xfer_end) begin
                    if (idx != LastIdx) begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = b2b ? ST_SETUP : ST_GAP;
                    end else if (!phase_rd) begin
                        idx_nxt      = '0;
                        phase_rd_nxt = 1'b1;
                        state_nxt    = b2b ? ST_SETUP : ST_GAP;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end

            ST_GAP: begin
                state_nxt = ST_SETUP;
            end

            ST_DONE: begin
                if (!start) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= ST_IDLE;
            idx      <= '0;
            phase_rd <= 1'b0;
            b2b      <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            phase_rd <= phase_rd_nxt;
            b2b      <= b2b_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Event counters: cleared when a run starts, otherwise saturating.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            err_count      <= 8'd0;
            mismatch_count <= 8'd0;
            timeout_count  <= 8'd0;
        end else if (cnt_clr) begin
            err_count      <= 8'd0;
            mismatch_count <= 8'd0;
            timeout_count  <= 8'd0;
        end else begin
            err_count      <= sat_inc(err_count, err_inc);
            mismatch_count <= sat_inc(mismatch_count, mis_inc);
            timeout_count  <= sat_inc(timeout_count, to_inc);
        end
    end

endmodule

// File: tb/tb_apb3_requester_traffic_gen.sv
// Directed bench for the APB3 traffic generator with a small word-memory completer model.
// Latency: checks transfer ordering, ACCESS lengths and busy/gap cycle counts per run.
// Backpressure: the completer model injects pready stalls, pslverr and read corruption.
module tb_apb3_requester_traffic_gen;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       start;
    logic       back2back;
    logic       busy;
    logic       done;
    logic [7:0] err_count;
    logic [7:0] mismatch_count;
    logic [7:0] timeout_count;

    always #5 pclk = ~pclk;

    apb3_requester_traffic_gen_if #(.AddressWidth(32), .DataWidth(32)) bus ();

    apb3_requester_traffic_gen dut (
        .pclk           (pclk),
        .presetn        (presetn),
        .start          (start),
        .back2back      (back2back),
        .apb            (bus.master),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .mismatch_count (mismatch_count),
        .timeout_count  (timeout_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Completer model controls.
    logic        clr;
    logic        corrupt3;
    logic        stall_wr2;
    logic        stall_rd0;
    int          err_word;
    int          wcnt;
    logic [31:0] mem [8];
    logic [2:0]  word;

    assign word = bus.paddr[4:2];

    // Completer responses.
    always_comb begin
        bus.pready = 1'b1;
        if (stall_wr2 && bus.psel && bus.penable && bus.pwrite && word == 3'd2 && wcnt < 3)
            bus.pready = 1'b0;
        if (stall_rd0 && bus.psel && bus.penable && !bus.pwrite && word == 3'd0)
            bus.pready = 1'b0;
        bus.pslverr = (err_word >= 0) && bus.pwrite && (int'(word) == err_word);
        bus.prdata  = mem[word] ^ ((corrupt3 && word == 3'd3) ? 32'h1 : 32'h0);
    end

    // Stall length tracking and memory writes.
    always @(posedge pclk) begin
        if (bus.psel && bus.penable && !bus.pready) wcnt <= wcnt + 1;
        else                                        wcnt <= 0;
        if (clr) begin
            for (int k = 0; k < 8; k++) mem[k] <= 32'h0;
        end else if (bus.psel && bus.penable && bus.pready && bus.pwrite) begin
            mem[word] <= bus.pwdata;
        end
    end

    // Transfer log, captured at SETUP; ACCESS length and stability per transfer.
    logic [31:0] l_addr [64];
    logic [31:0] l_data [64];
    logic        l_wr   [64];
    int          l_len  [64];
    logic        l_unst [64];
    int          nx;
    int          busy_cyc;
    int          gap_cyc;

    always @(negedge pclk) begin
        if (clr) begin
            nx       <= 0;
            busy_cyc <= 0;
            gap_cyc  <= 0;
        end else begin
            if (busy)          busy_cyc <= busy_cyc + 1;
            if (busy && !bus.psel) gap_cyc <= gap_cyc + 1;
            if (bus.psel && !bus.penable && nx < 64) begin
                l_addr[nx] <= bus.paddr;
                l_data[nx] <= bus.pwdata;
                l_wr[nx]   <= bus.pwrite;
                l_len[nx]  <= 0;
                l_unst[nx] <= 1'b0;
                nx         <= nx + 1;
            end else if (bus.psel && bus.penable && nx > 0) begin
                l_len[nx-1] <= l_len[nx-1] + 1;
                if (bus.paddr !== l_addr[nx-1] || bus.pwdata !== l_data[nx-1] ||
                    bus.pwrite !== l_wr[nx-1])
                    l_unst[nx-1] <= 1'b1;
            end
        end
    end

    task automatic clear_logs();
        clr = 1'b1;
        repeat (2) @(negedge pclk);
        clr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 400 && !done; c++) @(negedge pclk);
        check({tag, "_done"}, done, 1);
        @(negedge pclk);
    endtask

    task automatic run_seq(input logic b2b, input string tag);
        clear_logs();
        back2back = b2b;
        start     = 1'b1;
        wait_done(tag);
    endtask

    // Expected traffic: 8 writes of A5A50000+i to 4*i, then 8 reads of the same addresses.
    task automatic verify_traffic(input string tag);
        logic [63:0] exp;
        check({tag, "_nx"}, nx, 16);
        for (int n = 0; n < 16; n++) begin
            if (n < 8) exp = {31'(n * 4), 1'b1, 32'hA5A5_0000 + 32'(n)};
            else       exp = {31'((n - 8) * 4), 1'b0, 32'h0};
            check($sformatf("%s_x%0d", tag, n), {l_addr[n][30:0], l_wr[n], l_data[n]}, exp);
        end
    endtask

    task automatic check_counts(input string tag, input int e, input int m, input int t);
        check({tag, "_err"}, err_count, 64'(e));
        check({tag, "_mis"}, mismatch_count, 64'(m));
        check({tag, "_to"},  timeout_count, 64'(t));
    endtask

    initial begin
        presetn   = 1'b0;
        start     = 1'b0;
        back2back = 1'b0;
        clr       = 1'b1;
        corrupt3  = 1'b0;
        stall_wr2 = 1'b0;
        stall_rd0 = 1'b0;
        err_word  = -1;
        repeat (2) @(negedge pclk);

        // Reset state.
        check("rst_psel", bus.psel, 0);
        check("rst_penable", bus.penable, 0);
        check("rst_paddr", bus.paddr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_counts("rst", 0, 0, 0);
        presetn = 1'b1;
        clr     = 1'b0;
        @(negedge pclk);

        // Back-to-back run: 16 transfers, 32 busy cycles, psel never drops.
        run_seq(1'b1, "b2b");
        check("b2b_busy", busy_cyc, 32);
        check("b2b_gaps", gap_cyc, 0);
        verify_traffic("b2b");
        check_counts("b2b", 0, 0, 0);

        // DONE holds while start stays high, then falls one cycle after start drops.
        repeat (3) @(negedge pclk);
        check("hold_done", done, 1);
        start = 1'b0;
        @(posedge pclk);
        #1;
        check("rel_done", done, 0);
        check("rel_busy", busy, 0);
        @(negedge pclk);

        // Restart gives identical traffic.
        run_seq(1'b1, "rerun");
        check("rerun_busy", busy_cyc, 32);
        verify_traffic("rerun");
        start = 1'b0;
        @(negedge pclk);

        // Spaced run: one idle cycle between transfers, 16*2 + 15 busy cycles.
        run_seq(1'b0, "gap");
        check("gap_busy", busy_cyc, 47);
        check("gap_gaps", gap_cyc, 15);
        verify_traffic("gap");
        check_counts("gap", 0, 0, 0);
        start = 1'b0;
        @(negedge pclk);

        // Corrupted read word 3 and slave error on write word 5.
        corrupt3 = 1'b1;
        err_word = 5;
        run_seq(1'b1, "errs");
        check_counts("errs", 1, 1, 0);
        corrupt3 = 1'b0;
        err_word = -1;
        start    = 1'b0;
        @(negedge pclk);

        // Three wait states on write word 2; read word 0 never answers and times out.
        stall_wr2 = 1'b1;
        stall_rd0 = 1'b1;
        run_seq(1'b1, "stall");
        check("stall_len_w2", l_len[2], 4);
        check("stall_stable_w2", l_unst[2], 0);
        check("stall_len_r0", l_len[8], 16);
        check("stall_len_r1", l_len[9], 1);
        check("stall_busy", busy_cyc, 50);
        verify_traffic("stall");
        check_counts("stall", 0, 0, 1);
        stall_wr2 = 1'b0;
        stall_rd0 = 1'b0;
        start     = 1'b0;
        @(negedge pclk);

        // Reset during ACCESS of write word 4, then restart with start held high.
        clear_logs();
        err_word  = 1;
        back2back = 1'b1;
        start     = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge pclk);
            if (bus.psel && bus.penable && bus.pwrite && bus.paddr == 32'h10) break;
        end
        check("mid_found", {bus.psel, bus.penable, bus.paddr}, {2'b11, 32'h10});
        check("mid_err_before", err_count, 1);
        presetn = 1'b0;
        #1;
        check("mid_psel", bus.psel, 0);
        check("mid_penable", bus.penable, 0);
        check("mid_busy", busy, 0);
        check_counts("mid", 0, 0, 0);
        err_word = -1;
        clear_logs();
        presetn = 1'b1;
        @(posedge pclk);
        #1;
        check("restart_first", {bus.psel, bus.penable, bus.pwrite, bus.paddr},
              {3'b101, 32'h0});
        wait_done("restart");
        check("restart_busy", busy_cyc, 32);
        verify_traffic("restart");
        check_counts("restart", 0, 0, 0);
        start = 1'b0;
        @(negedge pclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
